// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: opcodes, FSM states, default width.
package alu_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_SLT  = 2'd2;
    localparam logic [1:0] ALU_SHL4 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_func.sv
// Purely combinational ALU: add, subtract, signed less-than, shift B left by four.
module alu_func
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [1:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        out = '0;
        case (ctl)
            ALU_ADD:  out = a + b;
            ALU_SUB:  out = a - b;
            ALU_SLT:  out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SHL4: out = b << 4;
            default:  out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU between N_REQ valid/ready requesters.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_zero,
    output logic                   busy,
    output logic [CNT_W-1:0]       ops_done
);

    localparam int GW = $clog2(N_REQ);

    state_t            state, state_nxt;
    logic [GW-1:0]     last_gnt, gnt_q, gnt_c;
    logic              found, accept, rsp_done;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  a_q, b_q, alu_out;
    logic              alu_zero;

    // Search starts just after the last completed grant and wraps, giving strict rotation.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        gnt_c = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last_gnt) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt_c = GW'(idx);
            end
        end
    end

    assign accept   = (state == IDLE) && found;
    assign rsp_done = (state == RESP) && rsp_ready[gnt_q];
    assign busy     = (state != IDLE);

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (accept)         req_ready[gnt_c] = 1'b1;
        if (state == RESP)  rsp_valid[gnt_q] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = EXEC;
            EXEC:                  state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        else        state <= state_nxt;
    end

    alu_func #(.WIDTH(WIDTH)) u_alu (
        .ctl  (op_q),
        .a    (a_q),
        .b    (b_q),
        .out  (alu_out),
        .zero (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand latches are reset too, so a freshly reset block shows a known result path.
            last_gnt <= GW'(N_REQ - 1);
            gnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            ops_done <= '0;
        end else begin
            if (accept) begin
                gnt_q <= gnt_c;
                op_q  <= req_op[2*gnt_c +: 2];
                a_q   <= req_a[WIDTH*gnt_c +: WIDTH];
                b_q   <= req_b[WIDTH*gnt_c +: WIDTH];
            end
            if (state == EXEC) begin
                rsp_data <= alu_out;
                rsp_zero <= alu_zero;
            end
            if (rsp_done) begin
                last_gnt <= gnt_q;
                if (ops_done != '1) ops_done <= ops_done + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with two requesters.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a, req_b;
    logic [7:0]  rsp_data;
    logic        rsp_zero, busy;
    logic [15:0] ops_done;

    int checks   = 0;
    int failures = 0;
    int exp_ops  = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(8), .N_REQ(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*r +: 2] = op;
        req_a[8*r +: 8]  = a;
        req_b[8*r +: 8]  = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) tick();
        rst_n   = 1'b1;
        exp_ops = 0;
        tick();
    endtask

    // Single requester op; operands are scrambled right after accept.
    task automatic run_op(input int r, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_d, input logic exp_z, input string tag);
        int n;
        n = 0;
        rsp_ready    = '1;
        set_req(r, op, a, b);
        req_valid[r] = 1'b1;
        #1;
        while (!req_ready[r] && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'(1 << r));
        tick();
        req_valid[r] = 1'b0;
        set_req(r, ~op, ~a, ~b);
        #1;
        check({tag, "_exec"}, {busy, 30'd0, rsp_valid == 2'b00}, {1'b1, 30'd0, 1'b1});
        tick();
        check({tag, "_valid"}, 32'(rsp_valid), 32'(1 << r));
        check({tag, "_data"}, {23'd0, rsp_zero, rsp_data}, {23'd0, exp_z, exp_d});
        tick();
        exp_ops++;
        check({tag, "_done"}, {14'd0, rsp_valid, ops_done}, {16'd0, 16'(exp_ops)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        check("rst_rsp", {23'd0, rsp_zero, rsp_data}, 32'd0);

        run_op(0, ALU_ADD,  8'h05, 8'h03, 8'h08, 1'b0, "add");
        run_op(1, ALU_SUB,  8'h03, 8'h03, 8'h00, 1'b1, "sub_zero");
        run_op(1, ALU_SLT,  8'hFF, 8'h01, 8'h01, 1'b0, "slt_neg");
        run_op(1, ALU_SLT,  8'h01, 8'hFF, 8'h00, 1'b1, "slt_pos");
        run_op(1, ALU_SHL4, 8'h00, 8'h1F, 8'hF0, 1'b0, "shl4");

        // Both requesters valid from reset: grants rotate 0,1,0,1.
        do_reset();
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            int r;
            r = i % 2;
            set_req(0, ALU_ADD, 8'(i), 8'h01);
            set_req(1, ALU_SUB, 8'h10, 8'(i));
            #1;
            check("rr_ready", 32'(req_ready), 32'(1 << r));
            check("rr_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            tick();
            tick();
            check("rr_valid", 32'(rsp_valid), 32'(1 << r));
            check("rr_data", 32'(rsp_data), (r == 0) ? 32'(8'(i + 1)) : 32'(8'(16 - i)));
            tick();
            exp_ops++;
            check("rr_ops", 32'(ops_done), 32'(exp_ops));
        end

        // Backpressure on requester 0; rsp_ready[1] high must be ignored.
        set_req(0, ALU_ADD, 8'h20, 8'h22);
        set_req(1, ALU_SHL4, 8'h00, 8'h03);
        rsp_ready = 2'b10;
        #1;
        check("bp_ready0", 32'(req_ready), 32'd1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {busy, 13'd0, req_ready, rsp_valid, rsp_data, 8'd0},
                  {1'b1, 13'd0, 2'b00, 2'b01, 8'h42, 8'd0});
            tick();
        end
        rsp_ready = 2'b11;
        tick();
        exp_ops++;
        check("bp_idle", {busy, 13'd0, req_ready, ops_done}, {1'b1 ^ 1'b1, 13'd0, 2'b10, 16'(exp_ops)});
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        check("bp_req1", {22'd0, rsp_valid, rsp_data}, {22'd0, 2'b10, 8'h30});
        tick();

        // Reset during RESP abandons the op and restores the pointer.
        do_reset();
        run_op(0, ALU_ADD, 8'h01, 8'h01, 8'h02, 1'b0, "pre1");
        run_op(0, ALU_SUB, 8'h01, 8'h02, 8'hFF, 1'b0, "pre2");
        run_op(0, ALU_ADD, 8'h80, 8'h80, 8'h00, 1'b1, "pre3");
        set_req(0, ALU_ADD, 8'h07, 8'h07);
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        check("mid_resp", {14'd0, rsp_valid, ops_done}, {14'd0, 2'b01, 16'd3});
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst", {busy, 13'd0, rsp_valid, ops_done}, {1'b0, 13'd0, 2'b00, 16'd0});
        tick();
        rst_n     = 1'b1;
        req_valid = 2'b11;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 8-bit ALU datapath between N_REQ requesters (default 2), e.g. the main datapath and an address/branch-compare unit.
- Arbitration is round-robin with a valid/ready request handshake.
- Each accepted operation is registered, executed, and its result and zero flag are returned through a per-requester valid/ready response channel.
- It sits between the requesters and the ALU function, which is instantiated inside this block.

Parameters:
- WIDTH, 8, operand and result width in bits.
- N_REQ, 2, number of requesters; legal range 2..4.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accept; one-hot or zero.
- req_op  in  2*N_REQ  per-requester ALU control; slice i is [2i+1:2i].
- req_a  in  WIDTH*N_REQ  per-requester operand A, packed.
- req_b  in  WIDTH*N_REQ  per-requester operand B, packed.
- rsp_valid  out  N_REQ  per-requester result valid; one-hot or zero.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_data  out  WIDTH  result, shared by all requesters; qualified by rsp_valid.
- rsp_zero  out  1  high when rsp_data == 0.
- busy  out  1  high in any state other than IDLE.
- ops_done  out  CNT_W  count of completed responses; saturating.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - Round-robin pointer last_gnt = N_REQ-1, so requester 0 wins first.
  - rsp_data = 0, rsp_zero = 0, rsp_valid = 0, req_ready = 0, busy = 0, ops_done = 0.
  - Latched op/a/b/gnt registers = 0.
- Opcodes (2-bit, WIDTH bits wide):
  - 0: A+B, modulo 2^WIDTH.
  - 1: A-B, modulo 2^WIDTH.
  - 2: signed less-than. Compare sign-extended {A[MSB],A} < {B[MSB],B}; result is 1 or 0, zero-extended.
  - 3: B << 4; upper bits are discarded.
- States:
  - IDLE:
    - gnt = first requester with req_valid high, searching from last_gnt+1 and wrapping modulo N_REQ.
    - req_ready[gnt] = 1 combinationally in this cycle only.
    - On the handshake, latch op/a/b/gnt and go to EXEC.
    - If no req_valid, stay in IDLE; req_ready = 0.
  - EXEC (1 cycle):
    - ALU output is registered into rsp_data and rsp_zero.
    - Go to RESP.
  - RESP:
    - rsp_valid[gnt] = 1; rsp_data and rsp_zero are held stable.
    - On rsp_ready[gnt]: go to IDLE, set last_gnt = gnt, and increment ops_done (saturate at all-ones).
    - rsp_ready on any non-granted index is ignored.
- Latency and throughput:
  - Request accepted at edge N gives rsp_valid from cycle N+2.
  - Minimum 3 cycles per operation; no overlap between operations.
- Request inputs are sampled only at the accept edge; changes afterwards do not affect the op in flight.
- A requester may drop req_valid before being granted; the request is not remembered.
- Round-robin fairness: with all requesters continuously valid, grants rotate strictly 0,1,…,N_REQ-1,0.
- Reset asserted mid-operation (EXEC or RESP) abandons the operation. rsp_valid drops asynchronously and ops_done is not incremented.
- Unknown or illegal opcodes cannot occur; the field is 2 bits and all four values are defined.

Decomposition:
- Shared package `alu_pkg`:
  - opcode constants ALU_ADD=0, ALU_SUB=1, ALU_SLT=2, ALU_SHL4=3.
  - state encoding IDLE/EXEC/RESP.
  - WIDTH default.
- One sub-module: `alu_func`, a purely combinational ALU (ctl, a, b -> out, zero) implementing the opcode table. It is instantiated once, fed from the latched operands.
- Round-robin grant logic stays inline.

Test Plan:
- Req0 op=0 A=0x05 B=0x03, rsp_ready held high -> req_ready[0] in the accept cycle; rsp_valid[0] 2 cycles later; rsp_data=0x08, rsp_zero=0, ops_done=1.
- Req1 op=1 A=0x03 B=0x03 -> rsp_data=0x00, rsp_zero=1. Then op=2 A=0xFF B=0x01 -> 0x01. Then op=2 A=0x01 B=0xFF -> 0x00. Then op=3 B=0x1F -> 0xF0.
- Both req_valid held high for 4 ops after reset -> grant order 0,1,0,1. Each response is delivered on the matching rsp_valid index only, and req_ready is never high for both.
- Response backpressure: hold rsp_ready[0]=0 for 5 cycles in RESP -> rsp_valid[0] and rsp_data stay stable, busy=1, and req1 stays unaccepted. Release -> IDLE next cycle, then req1 is granted.
- Change req_a/req_b/req_op the cycle after accept -> the result reflects the values sampled at accept.
- Assert rst_n=0 during RESP with ops_done=3 -> rsp_valid=0 immediately, ops_done=0, state IDLE. After release, req0 is granted first.
